// File: rtl/atm_dispense_pkg.sv
// Shared constants for the ATM cash dispenser: FSM states, note encodings,
// note values, status codes and the low-cash threshold.
package atm_dispense_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PLAN     = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_FINISH   = 2'd3;

  localparam logic [1:0] DENOM_10  = 2'b00;
  localparam logic [1:0] DENOM_20  = 2'b01;
  localparam logic [1:0] DENOM_50  = 2'b10;
  localparam logic [1:0] DENOM_100 = 2'b11;

  localparam logic [10:0] VAL_10  = 11'd10;
  localparam logic [10:0] VAL_20  = 11'd20;
  localparam logic [10:0] VAL_50  = 11'd50;
  localparam logic [10:0] VAL_100 = 11'd100;

  localparam logic [1:0] ERR_OK           = 2'b00;
  localparam logic [1:0] ERR_ZERO         = 2'b01;
  localparam logic [1:0] ERR_BAD_AMOUNT   = 2'b10;
  localparam logic [1:0] ERR_INSUFFICIENT = 2'b11;

  localparam int unsigned LOW_CASH_THR = 32'd4;

  function automatic logic [10:0] denom_value(input logic [1:0] d);
    logic [10:0] v;
    case (d)
      DENOM_10:  v = VAL_10;
      DENOM_20:  v = VAL_20;
      DENOM_50:  v = VAL_50;
      DENOM_100: v = VAL_100;
      default:   v = VAL_10;
    endcase
    return v;
  endfunction

  // Highest denomination whose flag is set; 10 when none is.
  function automatic logic [1:0] top_denom(input logic [3:0] flags);
    logic [1:0] d;
    if (flags[3]) begin
      d = DENOM_100;
    end else if (flags[2]) begin
      d = DENOM_50;
    end else if (flags[1]) begin
      d = DENOM_20;
    end else begin
      d = DENOM_10;
    end
    return d;
  endfunction

endpackage

// File: rtl/cash_dispenser_note_cassette.sv
// One note cassette: inventory counter with async reset-to-init,
// synchronous reload to init and single-note decrement.
module note_cassette #(
  parameter int CNT_W = 8,
  parameter int INIT  = 50
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Inventory count; the zero guard only matters if a caller misbehaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= INIT_CNT;
    end else if (load_i) begin
      cnt_q <= INIT_CNT;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cash_dispenser.sv
// Greedy note planner and dispenser over four cassettes (100/50/20/10).
// Optional macro LOW_CASH_EN adds the registered low_cash output.
module cash_dispenser
  import atm_dispense_pkg::*;
#(
  parameter int NOTE_CNT_W = 8,
  parameter int INIT_100   = 50,
  parameter int INIT_50    = 50,
  parameter int INIT_20    = 50,
  parameter int INIT_10    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_amount,
  input  logic        refill,
  output logic        busy,
  output logic        dispense_note,
  output logic [1:0]  note_denom,
  output logic        done,
  output logic        error,
`ifdef LOW_CASH_EN
  output logic        low_cash,
`endif
  output logic [1:0]  err_code
);

  localparam logic [NOTE_CNT_W-1:0] CNT_ONE = NOTE_CNT_W'(1);

  logic [1:0]            state_q, state_d;
  logic [10:0]           rem_q, rem_d;
  logic [NOTE_CNT_W-1:0] plan_q [4];
  logic [NOTE_CNT_W-1:0] plan_d [4];
  logic                  any_q, any_d;
  logic [1:0]            err_q, err_d;

  logic [NOTE_CNT_W-1:0] cnt_s [4];
  logic                  load_s;
  logic [3:0]            dec_s;
  logic [3:0]            usable_s;
  logic [3:0]            plan_nz_q_s;
  logic [3:0]            plan_nz_d_s;
  logic [1:0]            plan_pick_s;
  logic [1:0]            disp_pick_s;
  logic                  last_note_s;

  logic       req_ready_q;
  logic       busy_q;
  logic       dispense_note_q;
  logic [1:0] note_denom_q;
  logic       done_q;
  logic       error_q;
  logic [1:0] err_code_q;

  note_cassette #(.CNT_W(NOTE_CNT_W), .INIT(INIT_10)) u_cas_10 (
    .clk_i(clk), .rst_i(rst), .load_i(load_s), .dec_i(dec_s[0]), .cnt_o(cnt_s[0])
  );
  note_cassette #(.CNT_W(NOTE_CNT_W), .INIT(INIT_20)) u_cas_20 (
    .clk_i(clk), .rst_i(rst), .load_i(load_s), .dec_i(dec_s[1]), .cnt_o(cnt_s[1])
  );
  note_cassette #(.CNT_W(NOTE_CNT_W), .INIT(INIT_50)) u_cas_50 (
    .clk_i(clk), .rst_i(rst), .load_i(load_s), .dec_i(dec_s[2]), .cnt_o(cnt_s[2])
  );
  note_cassette #(.CNT_W(NOTE_CNT_W), .INIT(INIT_100)) u_cas_100 (
    .clk_i(clk), .rst_i(rst), .load_i(load_s), .dec_i(dec_s[3]), .cnt_o(cnt_s[3])
  );

  // A denomination is usable when it fits the remainder and the plan has not exhausted the cassette.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      usable_s[i]    = (rem_q >= denom_value(2'(i))) && (plan_q[i] < cnt_s[i]);
      plan_nz_q_s[i] = (plan_q[i] != '0);
      plan_nz_d_s[i] = (plan_d[i] != '0);
    end
    plan_pick_s = top_denom(usable_s);
    disp_pick_s = top_denom(plan_nz_q_s);
    last_note_s = (plan_q[disp_pick_s] == CNT_ONE) &&
                  ((plan_nz_q_s & ~(4'b0001 << disp_pick_s)) == 4'b0000);
  end

  // Next-state logic for the FSM, planner and cassette controls.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    plan_d  = plan_q;
    any_d   = any_q;
    err_d   = err_q;
    load_s  = 1'b0;
    dec_s   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d = req_amount;
          for (int i = 0; i < 4; i++) begin
            plan_d[i] = '0;
          end
          any_d   = 1'b0;
          err_d   = ERR_OK;
          state_d = ST_PLAN;
        end else begin
          load_s = refill;
        end
      end
      ST_PLAN: begin
        if (rem_q == 11'd0) begin
          if (any_q) begin
            state_d = ST_DISPENSE;
          end else begin
            err_d   = ERR_ZERO;
            state_d = ST_FINISH;
          end
        end else if (usable_s != 4'b0000) begin
          plan_d[plan_pick_s] = plan_q[plan_pick_s] + CNT_ONE;
          rem_d               = rem_q - denom_value(plan_pick_s);
          any_d               = 1'b1;
        end else if (rem_q < VAL_10) begin
          err_d   = ERR_BAD_AMOUNT;
          state_d = ST_FINISH;
        end else begin
          err_d   = ERR_INSUFFICIENT;
          state_d = ST_FINISH;
        end
      end
      ST_DISPENSE: begin
        if (plan_nz_q_s != 4'b0000) begin
          dec_s[disp_pick_s]  = 1'b1;
          plan_d[disp_pick_s] = plan_q[disp_pick_s] - CNT_ONE;
          if (last_note_s) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_DISPENSE;
          end
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rem_q           <= 11'd0;
      for (int i = 0; i < 4; i++) begin
        plan_q[i] <= '0;
      end
      any_q           <= 1'b0;
      err_q           <= ERR_OK;
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      dispense_note_q <= 1'b0;
      note_denom_q    <= DENOM_10;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      err_code_q      <= ERR_OK;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      plan_q          <= plan_d;
      any_q           <= any_d;
      err_q           <= err_d;
      req_ready_q     <= (state_d == ST_IDLE);
      busy_q          <= (state_d != ST_IDLE);
      dispense_note_q <= (state_d == ST_DISPENSE);
      note_denom_q    <= (state_d == ST_DISPENSE) ? top_denom(plan_nz_d_s) : DENOM_10;
      done_q          <= (state_d == ST_FINISH);
      error_q         <= (state_d == ST_FINISH) && (err_d != ERR_OK);
      err_code_q      <= (state_d == ST_FINISH) ? err_d : ERR_OK;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign dispense_note = dispense_note_q;
  assign note_denom    = note_denom_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;

`ifdef LOW_CASH_EN
  localparam logic [NOTE_CNT_W-1:0] LOW_THR = NOTE_CNT_W'(LOW_CASH_THR);
  logic low_cash_q;

  // Low-cash flag follows cassette counts one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cash_q <= 1'b0;
    end else begin
      low_cash_q <= (cnt_s[0] < LOW_THR) || (cnt_s[1] < LOW_THR) ||
                    (cnt_s[2] < LOW_THR) || (cnt_s[3] < LOW_THR);
    end
  end

  assign low_cash = low_cash_q;
`endif

endmodule

// File: tb/tb_cash_dispenser.sv
// Bench for cash_dispenser: transaction-level greedy model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cash_dispenser;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       note;
    logic [1:0] denom;
    logic       done;
    logic       error;
    logic [1:0] code;
  } out_t;

  typedef struct packed {
    logic [3:0][15:0] p;
    int               k;
    logic [1:0]       code;
  } plan_t;

  localparam out_t IDLE_T = '{ready: 1'b1, busy: 1'b0, note: 1'b0, denom: 2'd0,
                              done: 1'b0, error: 1'b0, code: 2'd0};
  localparam int INIT_V [4] = '{50, 50, 50, 50};
  localparam int VALS   [4] = '{10, 20, 50, 100};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_amount;
  logic        refill;
  logic        busy;
  logic        dispense_note;
  logic [1:0]  note_denom;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  cash_dispenser dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .refill(refill), .busy(busy),
    .dispense_note(dispense_note), .note_denom(note_denom), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Greedy breakdown from the rules: highest usable note first, no backtracking.
  function automatic plan_t greedy(input int amt, input int inv[4]);
    plan_t r;
    int rem;
    int p[4];
    bit go;
    bit f;
    r   = '0;
    rem = amt;
    p   = '{0, 0, 0, 0};
    go  = 1'b1;
    while (go) begin
      if (rem == 0) begin
        r.code = (r.k == 0) ? 2'd1 : 2'd0;
        go = 1'b0;
      end else begin
        f = 1'b0;
        for (int d = 3; d >= 0; d--) begin
          if (!f && rem >= VALS[d] && p[d] < inv[d]) begin
            p[d]++;
            rem -= VALS[d];
            r.k++;
            f = 1'b1;
          end
        end
        if (!f) begin
          r.code = (rem < 10) ? 2'd2 : 2'd3;
          go = 1'b0;
        end
      end
    end
    for (int d = 0; d < 4; d++) r.p[d] = 16'(p[d]);
    return r;
  endfunction

  function automatic int last_t(input plan_t r);
    return (r.code == 2'd0) ? 2 * r.k + 2 : r.k + 2;
  endfunction

  // Expected outputs t cycles after acceptance: k+1 planning cycles, k notes, one status cycle.
  function automatic out_t exp_at(input int t, input plan_t r);
    out_t o;
    int j;
    int cum;
    bit f;
    o = '0;
    o.busy = 1'b1;
    if (t >= last_t(r)) begin
      o.done  = 1'b1;
      o.error = (r.code != 2'd0);
      o.code  = r.code;
    end else if (t >= r.k + 2) begin
      j = t - r.k - 2;
      cum = 0;
      f = 1'b0;
      o.note = 1'b1;
      for (int d = 3; d >= 0; d--) begin
        if (!f && j < cum + int'(r.p[d])) begin
          o.denom = 2'(d);
          f = 1'b1;
        end
        cum += int'(r.p[d]);
      end
    end
    return o;
  endfunction

  bit    m_busy;
  int    m_t;
  plan_t m_plan;
  int    m_inv [4];

  // Transaction model: advances one step per clock, reset restores full cassettes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_plan <= '0;
      for (int i = 0; i < 4; i++) m_inv[i] <= INIT_V[i];
    end else if (!m_busy) begin
      if (req_valid) begin : accept_blk
        plan_t r;
        r = greedy(int'(req_amount), m_inv);
        m_plan <= r;
        m_busy <= 1'b1;
        m_t    <= 1;
        if (r.code == 2'd0) begin
          for (int i = 0; i < 4; i++) m_inv[i] <= m_inv[i] - int'(r.p[i]);
        end
      end else if (refill) begin
        for (int i = 0; i < 4; i++) m_inv[i] <= INIT_V[i];
      end
    end else if (m_t >= last_t(m_plan)) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic [1:0] obs_notes [$];
  int         done_total = 0;
  int         busy_total = 0;
  logic [1:0] last_code  = 2'd0;
  logic       last_err   = 1'b0;

  // Per-cycle compare against the model, plus a record of what the DUT emitted.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      out_t act;
      out_t expv;
      act  = '{ready: req_ready, busy: busy, note: dispense_note, denom: note_denom,
               done: done, error: error, code: err_code};
      expv = m_busy ? exp_at(m_t, m_plan) : IDLE_T;
      check("cycle_outputs", 32'(act), 32'(expv));
      if (!m_busy) begin
        for (int i = 0; i < 4; i++) check("inventory", 32'(dut.cnt_s[i]), 32'(m_inv[i]));
      end
      if (dispense_note) obs_notes.push_back(note_denom);
      if (busy) busy_total++;
      if (done) begin
        done_total++;
        last_code = err_code;
        last_err  = error;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (!m_busy) return;
      @(posedge clk);
      #1;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  int n0, d0, b0;

  task automatic do_req(input int amt);
    wait_idle();
    n0 = obs_notes.size();
    d0 = done_total;
    b0 = busy_total;
    req_valid  = 1'b1;
    req_amount = 11'(amt);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();
  endtask

  // Notes since n0, packed base-4 in emission order, checked with their count.
  task automatic chk_notes(input string nm, input int cnt, input int val);
    int v;
    v = 0;
    for (int i = n0; i < obs_notes.size(); i++) v = v * 4 + int'(obs_notes[i]);
    check({nm, "_count"}, 32'(obs_notes.size() - n0), 32'(cnt));
    check({nm, "_order"}, 32'(v), 32'(val));
  endtask

  task automatic chk_inv(input string nm, input int a, input int b, input int c, input int d);
    check({nm, "_c10"},  32'(dut.cnt_s[0]), 32'(a));
    check({nm, "_c20"},  32'(dut.cnt_s[1]), 32'(b));
    check({nm, "_c50"},  32'(dut.cnt_s[2]), 32'(c));
    check({nm, "_c100"}, 32'(dut.cnt_s[3]), 32'(d));
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_amount = 11'd0;
    refill = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    chk_inv("rst_inv", 50, 50, 50, 50);

    do_req(180);
    chk_notes("t1_notes", 4, 'hE4);
    check("t1_done", 32'(done_total - d0), 32'd1);
    check("t1_code", 32'(last_code), 32'd0);
    check("t1_busy_cycles", 32'(busy_total - b0), 32'd10);
    chk_inv("t1_inv", 49, 49, 49, 49);

    do_req(0);
    chk_notes("t2_notes", 0, 0);
    check("t2_err", 32'(last_err), 32'd1);
    check("t2_code", 32'(last_code), 32'd1);
    chk_inv("t2_inv", 49, 49, 49, 49);

    do_req(65);
    chk_notes("t3_notes", 0, 0);
    check("t3_code", 32'(last_code), 32'd2);
    check("t3_busy_cycles", 32'(busy_total - b0), 32'd4);
    chk_inv("t3_inv", 49, 49, 49, 49);

    for (int i = 0; i < 49; i++) do_req(10);
    check("t4_drain10", 32'(dut.cnt_s[0]), 32'd0);
    do_req(60);
    chk_notes("t4_60_notes", 0, 0);
    check("t4_60_code", 32'(last_code), 32'd3);
    check("t4_60_busy_cycles", 32'(busy_total - b0), 32'd3);
    do_req(40);
    chk_notes("t4_40_notes", 2, 'h5);
    check("t4_40_code", 32'(last_code), 32'd0);

    for (int i = 0; i < 4; i++) do_req(1000);
    for (int i = 0; i < 7; i++) do_req(100);
    check("t5_drain100", 32'(dut.cnt_s[3]), 32'd2);
    do_req(300);
    chk_notes("t5_300_notes", 4, 'hFA);
    do_req(100);
    chk_notes("t5_100_notes", 2, 'hA);
    check("t5_100_code", 32'(last_code), 32'd0);
    chk_inv("t5_inv", 0, 47, 45, 0);
    wait_idle();
    refill = 1'b1;
    @(posedge clk);
    #1 refill = 1'b0;
    chk_inv("t5_refill", 50, 50, 50, 50);

    wait_idle();
    n0 = obs_notes.size();
    d0 = done_total;
    req_valid  = 1'b1;
    req_amount = 11'd180;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_notes("t6_notes", 1, 'h3);
    check("t6_no_done", 32'(done_total - d0), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    chk_inv("t6_inv", 50, 50, 50, 50);

    wait_idle();
    req_valid  = 1'b1;
    req_amount = 11'd180;
    @(posedge clk);
    #1 req_valid = 1'b0;
    refill = 1'b1;
    @(posedge clk);
    #1 refill = 1'b0;
    wait_idle();
    chk_inv("t6_busy_refill", 49, 49, 49, 49);

    for (int c = 0; c < 3000; c++) begin
      int sel;
      sel = int'($urandom % 8);
      req_valid = ($urandom % 3 == 0);
      if (sel == 0)      req_amount = 11'd0;
      else if (sel == 1) req_amount = 11'($urandom % 2048);
      else if (sel == 2) req_amount = 11'(10 * $urandom_range(1, 204));
      else               req_amount = 11'(10 * $urandom_range(1, 60));
      refill = ($urandom % 30 == 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    refill = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cash_dispenser.md
Name: cash_dispenser

Overview:
Cash-handling end of the ATM withdraw path. The ATM controller approves a withdrawal amount and hands it over on a valid/ready handshake. This block plans a greedy note breakdown from four cassettes (100/50/20/10), checks it against cassette inventory, and only then dispenses. It emits one note pulse per cycle and finishes with a done/error status pulse.

Parameters:
NOTE_CNT_W, 8, width of each cassette inventory counter and each plan counter.
INIT_100, 50, notes loaded into the 100 cassette at reset/refill.
INIT_50, 50, notes loaded into the 50 cassette at reset/refill.
INIT_20, 50, notes loaded into the 20 cassette at reset/refill.
INIT_10, 50, notes loaded into the 10 cassette at reset/refill.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  withdrawal request valid.
req_ready  out  1  block can accept a request; high only in IDLE.
req_amount  in  11  requested amount, unsigned, range 0..2047.
refill  in  1  reload all cassettes to INIT_*; honoured only in IDLE.
busy  out  1  high in every state except IDLE.
dispense_note  out  1  one-cycle pulse per note delivered.
note_denom  out  2  denomination of the current note: 00=10, 01=20, 10=50, 11=100; 00 when no note.
done  out  1  one-cycle pulse ending every accepted request.
error  out  1  valid with done; 1 means the request failed and no notes were dispensed.
err_code  out  2  valid with done: 00 OK, 01 ZERO, 10 BAD_AMOUNT, 11 INSUFFICIENT.

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous, active-high.
- Reset values: state=IDLE; all cassettes=INIT_*; plan counters=0; dispense_note, note_denom, done, error, err_code, busy all 0. req_ready=1 once rst deasserts.
- States: IDLE, PLAN, DISPENSE, FINISH.
- IDLE:
  - Accept on req_valid & req_ready. Latch req_amount into rem (11b) and clear the plan counters. Next state PLAN.
  - If refill is high and no request is accepted that cycle, load INIT_* into all cassettes.
  - If refill and a request coincide, the request wins and refill is ignored.
- PLAN (one decision per cycle, greedy, highest denomination first):
  - rem==0 on the first PLAN cycle: FINISH with err=ZERO.
  - rem>=100 and plan100<cnt100: plan100++, rem-=100. Otherwise apply the same test to 50, then 20, then 10.
  - rem==0 after at least one note: go to DISPENSE.
  - 0<rem<10: FINISH with err=BAD_AMOUNT.
  - rem>=10 but no denomination is usable: FINISH with err=INSUFFICIENT.
  - Greedy is the defined behaviour. No backtracking (e.g. 60 with an empty 10 cassette fails even when three 20s exist).
- DISPENSE:
  - Each cycle, the highest denomination with a nonzero plan count emits dispense_note=1 with the matching note_denom.
  - On that cycle, that denomination's cassette and plan counter both decrement.
  - When all plan counters reach 0: go to FINISH.
  - Notes appear in non-increasing denomination order, back-to-back, with no gaps.
- FINISH: done=1 for one cycle, with error=(err!=OK) and err_code. Next state IDLE.
- Inventory changes only in DISPENSE. A failed request leaves all cassettes untouched.
- Latency: accept at cycle 0; PLAN runs N+1 cycles for N notes; DISPENSE runs N cycles; done follows 1 cycle later.
- Widths: cassettes never underflow, because the plan is bounded by the current count. rem never goes negative, because subtraction is guarded by compare.
- req_valid and req_amount are ignored outside IDLE. refill is ignored outside IDLE.
- Reset mid-operation: abort immediately, discard the plan, emit no done, restore cassettes to INIT_*. Notes already dispensed are not recorded.

Optional Feature:
Macro LOW_CASH_EN.
- Defined: adds output low_cash (1b), registered and reset to 0. It is high whenever any cassette count is <4, and updates the cycle after each cassette change.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package atm_dispense_pkg holds:
  - the state enum;
  - denomination encoding constants (DENOM_10..DENOM_100) and values 10/20/50/100;
  - error codes OK/ZERO/BAD_AMOUNT/INSUFFICIENT;
  - the LOW_CASH threshold, 4.
- One sub-module, note_cassette, instantiated 4x. It holds one inventory counter (NOTE_CNT_W) with async reset-to-init, load-init and decrement, and exposes its count.

Test Plan:
1. Reset, defaults. Request 180 → PLAN 5 cycles; notes 100,50,20,10 in 4 consecutive cycles; then done=1, error=0, err_code=00; every cassette reads 49.
2. Request 0 → done with error=1, err_code=01; no dispense_note pulses; inventory unchanged.
3. Request 65 → 50 and 10 are planned, then rem=5 → error=1, err_code=10; no notes dispensed; inventory unchanged.
4. INIT_10=0. Request 60 → 50 is planned, then no usable 10 → err_code=11, no notes. Then request 40 → notes 20,20, done OK.
5. INIT_100=2. Request 300 → notes 100,100,50,50. A follow-up request of 100 → note 50,50 (100 cassette empty). Refill → counts back to INIT_*.
6. Assert rst during the second DISPENSE cycle of a 180 request → no further pulses, no done, cassettes=INIT_*, req_ready=1 after rst drops. Refill pulsed while busy → ignored.
